// File: rtl/class_tree_sched.sv
// -----------------------------------------------------------------------------
// class_tree_sched
//
// Round-robin front end that lets N feature producers share a single
// combinational decision-tree classifier. One requester is granted at a time.
// Its feature vector is registered onto the shared tree input and held for
// SETTLE cycles. The tree output is then captured and returned, tagged with the
// requester index, through a valid/ready response channel.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   [N]          per-requester request valid
//   req_ready   [N]          one-hot grant (combinational, IDLE only)
//   req_feat    [N*FEAT_W]   packed feature vectors, requester k at k*FEAT_W
//   tree_feat   [FEAT_W]     registered vector driven to the shared tree
//   tree_class  [CLASS_W]    combinational tree output
//   rsp_valid               result valid
//   rsp_ready               downstream accepts result
//   rsp_id      [ID_W]       requester index of the result
//   rsp_class   [CLASS_W]    captured classification
//   busy                    high whenever the scheduler is not IDLE
//
// Optional build macro CLASS_TREE_SCHED_STATS_EN adds:
//   stat_done   [16]         wrapping count of response handshakes
//   stat_pos    [16]         wrapping count of handshakes with rsp_class != 0
// -----------------------------------------------------------------------------
module class_tree_sched #(
    parameter int N       = 4,
    parameter int FEAT_W  = 51,
    parameter int CLASS_W = 1,
    parameter int SETTLE  = 2,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req_valid,
    output logic [N-1:0]          req_ready,
    input  logic [N*FEAT_W-1:0]   req_feat,
    output logic [FEAT_W-1:0]     tree_feat,
    input  logic [CLASS_W-1:0]    tree_class,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [CLASS_W-1:0]    rsp_class,
`ifdef CLASS_TREE_SCHED_STATS_EN
    output logic [15:0]           stat_done,
    output logic [15:0]           stat_pos,
`endif
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SETTLE_WAIT = 2'd1,
        RESP        = 2'd2
    } state_t;

    // Counter only needs to hold SETTLE-1.
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t              state;
    logic [CNT_W-1:0]    settle_cnt;
    logic [ID_W-1:0]     last_grant;

    logic [N-1:0]        grant;
    logic                grant_any;
    logic [ID_W-1:0]     grant_id;
    logic [FEAT_W-1:0]   grant_feat;

    // Rotating priority: first pass covers indices above last_grant, second
    // pass wraps around to 0..last_grant. First hit wins.
    always_comb begin
        grant      = '0;
        grant_any  = 1'b0;
        grant_id   = '0;
        grant_feat = '0;
        for (int j = 0; j < N; j++) begin
            if (!grant_any && (j > int'(last_grant)) && req_valid[j]) begin
                grant_any  = 1'b1;
                grant      = '0;
                grant[j]   = 1'b1;
                grant_id   = ID_W'(j);
                grant_feat = req_feat[j*FEAT_W +: FEAT_W];
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!grant_any && (j <= int'(last_grant)) && req_valid[j]) begin
                grant_any  = 1'b1;
                grant      = '0;
                grant[j]   = 1'b1;
                grant_id   = ID_W'(j);
                grant_feat = req_feat[j*FEAT_W +: FEAT_W];
            end
        end
    end

    // Grant is only offered while idle and out of reset; it never looks at
    // rsp_ready, so a response handshake and a new grant cannot share a cycle.
    assign req_ready = (rst_n && (state == IDLE)) ? grant : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            last_grant <= ID_W'(N-1);
            tree_feat  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_class  <= '0;
`ifdef CLASS_TREE_SCHED_STATS_EN
            stat_done  <= '0;
            stat_pos   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // tree_feat is deliberately left untouched when idle.
                    if (grant_any) begin
                        tree_feat  <= grant_feat;
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        settle_cnt <= CNT_W'(SETTLE - 1);
                        state      <= SETTLE_WAIT;
                    end
                end
                SETTLE_WAIT: begin
                    if (settle_cnt == '0) begin
                        rsp_class <= tree_class;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                RESP: begin
                    // Result held until accepted; nothing can overwrite it.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
`ifdef CLASS_TREE_SCHED_STATS_EN
                        stat_done <= stat_done + 16'd1;
                        if (rsp_class != '0) begin
                            stat_pos <= stat_pos + 16'd1;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
